bsg_comm_link_reassembler: RTL and testbench



---
 rtl/bsg_comm_link_reassembler.sv | 200 ++++++++++++++++++++
 tb/tb_bsg_comm_link_reassembler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_comm_link_reassembler.sv
// Core-side receive reassembler: pulls channel-width slices round-robin from the
// active link channels and rebuilds full core words, inverse of the transmit striping.

module bsg_comm_link_reassembler_checker #(
  parameter int link_channels_p = 4
) (
  input logic                       clk_i,
  input logic                       reset_i,
  input logic [link_channels_p-1:0] active_channels_i,
  input logic [link_channels_p-1:0] unfused_yumi_o,
  input logic                       fused_valid_o,
  input logic                       fused_yumi_i
);

  logic [link_channels_p-1:0] prev_mask_r;
  logic                       run_r;

  // Remember last cycle's mask and whether that cycle was out of reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
    prev_mask_r <= active_channels_i;
  end

  // Handshake and configuration checks, only meaningful out of reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      a_yumi_onehot0: assert ($onehot0(unfused_yumi_o));
      a_fused_yumi_legal: assert (fused_valid_o || !fused_yumi_i);
      if (run_r) begin
        a_mask_stable: assert (active_channels_i == prev_mask_r);
      end
    end
  end

endmodule

module bsg_comm_link_reassembler #(
  parameter int channel_width_p = 8,
  parameter int core_channels_p = 4,
  parameter int link_channels_p = 4,
  parameter int width_p         = core_channels_p * channel_width_p
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [link_channels_p-1:0] active_channels_i,
  input  logic [link_channels_p-1:0] unfused_valid_i,
  input  logic [channel_width_p-1:0] unfused_data_i [link_channels_p],
  output logic [link_channels_p-1:0] unfused_yumi_o,
  output logic                       fused_valid_o,
  output logic [width_p-1:0]         fused_data_o,
  input  logic                       fused_yumi_i
);

  localparam int ptr_w_lp   = (link_channels_p > 1) ? $clog2(link_channels_p) : 1;
  localparam int cnt_w_lp   = (core_channels_p > 1) ? $clog2(core_channels_p) : 1;
  localparam int accum_n_lp = (core_channels_p > 1) ? core_channels_p - 1 : 1;
  localparam logic [cnt_w_lp-1:0] last_slice_lp = cnt_w_lp'(core_channels_p - 1);

  function automatic logic [ptr_w_lp-1:0] first_active(input logic [link_channels_p-1:0] mask);
    logic [ptr_w_lp-1:0]        idx;
    logic [link_channels_p-1:0] sh;
    logic                       found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < link_channels_p; i++) begin
      sh = mask >> i;
      if (!found && sh[0]) begin
        idx   = ptr_w_lp'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Next set mask bit strictly above ptr, wrapping; ptr itself if it is the only one.
  function automatic logic [ptr_w_lp-1:0] next_active(input logic [ptr_w_lp-1:0]        ptr,
                                                       input logic [link_channels_p-1:0] mask);
    logic [ptr_w_lp-1:0]        idx;
    logic [link_channels_p-1:0] sh;
    logic                       found;
    int                         c;
    idx   = ptr;
    found = 1'b0;
    for (int i = 1; i <= link_channels_p; i++) begin
      c  = (int'(ptr) + i) % link_channels_p;
      sh = mask >> c;
      if (!found && sh[0]) begin
        idx   = ptr_w_lp'(c);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  logic [ptr_w_lp-1:0]        chan_ptr_r, next_chan_ptr_s;
  logic [cnt_w_lp-1:0]        slice_cnt_r, next_slice_cnt_s;
  logic [channel_width_p-1:0] accum_r [accum_n_lp];
  logic [channel_width_p-1:0] next_accum_s [accum_n_lp];
  logic [width_p-1:0]         out_r, next_out_s;
  logic                       out_v_r, next_out_v_s;
  logic [width_p-1:0]         word_s;
  logic [channel_width_p-1:0] slice_s;
  logic                       final_s;
  logic                       take_s;

  assign slice_s = unfused_data_i[chan_ptr_r];
  assign final_s = (slice_cnt_r == last_slice_lp);
  // The final slice may only land when the output register is free or draining.
  assign take_s  = ~reset_i & unfused_valid_i[chan_ptr_r] & active_channels_i[chan_ptr_r]
                 & (~final_s | ~out_v_r | fused_yumi_i);

  if (core_channels_p > 1) begin : g_multi
    // Incoming slice is the top slice; accumulated slices fill the rest in order.
    always_comb begin
      word_s = '0;
      word_s[width_p-1 -: channel_width_p] = slice_s;
      for (int k = 0; k < core_channels_p - 1; k++) begin
        word_s[k*channel_width_p +: channel_width_p] = accum_r[k];
      end
    end
  end else begin : g_single
    assign word_s = slice_s;
  end

  // Next-state logic for pointer, slice counter, accumulator and output word.
  always_comb begin
    next_chan_ptr_s  = chan_ptr_r;
    next_slice_cnt_s = slice_cnt_r;
    next_accum_s     = accum_r;
    next_out_s       = out_r;
    next_out_v_s     = out_v_r;
    if (take_s) begin
      next_chan_ptr_s = next_active(chan_ptr_r, active_channels_i);
      if (final_s) begin
        next_out_s       = word_s;
        next_slice_cnt_s = '0;
      end else begin
        next_accum_s[slice_cnt_r] = slice_s;
        next_slice_cnt_s          = slice_cnt_r + cnt_w_lp'(1);
      end
    end else begin
      next_chan_ptr_s = chan_ptr_r;
    end
    if (take_s && final_s) begin
      next_out_v_s = 1'b1;
    end else if (fused_yumi_i) begin
      next_out_v_s = 1'b0;
    end else begin
      next_out_v_s = out_v_r;
    end
  end

  // State registers; reset drops any partial or pending word.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chan_ptr_r  <= first_active(active_channels_i);
      slice_cnt_r <= '0;
      for (int k = 0; k < accum_n_lp; k++) begin
        accum_r[k] <= '0;
      end
      out_r       <= '0;
      out_v_r     <= 1'b0;
    end else begin
      chan_ptr_r  <= next_chan_ptr_s;
      slice_cnt_r <= next_slice_cnt_s;
      accum_r     <= next_accum_s;
      out_r       <= next_out_s;
      out_v_r     <= next_out_v_s;
    end
  end

  // Dequeue only the pointed channel, and only when its slice is taken.
  always_comb begin
    unfused_yumi_o = '0;
    if (take_s) begin
      unfused_yumi_o = link_channels_p'(1) << chan_ptr_r;
    end else begin
      unfused_yumi_o = '0;
    end
  end

  assign fused_valid_o = out_v_r;
  assign fused_data_o  = out_r;

  bsg_comm_link_reassembler_checker #(
    .link_channels_p(link_channels_p)
  ) checker_i (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .active_channels_i(active_channels_i),
    .unfused_yumi_o   (unfused_yumi_o),
    .fused_valid_o    (fused_valid_o),
    .fused_yumi_i     (fused_yumi_i)
  );

endmodule

// File: tb/tb_bsg_comm_link_reassembler.sv
// Bench for bsg_comm_link_reassembler: table-driven streams plus hand-written
// stall, reset and empty-mask sequences, with a scoreboard on the fused output.

module tb_bsg_comm_link_reassembler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mask;
  logic [3:0]  valid;
  logic [7:0]  udata [4];
  logic [3:0]  uyumi;
  logic        fvalid;
  logic [31:0] fdata;
  logic        yumi_en;
  logic        fyumi;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  // A well-behaved consumer only dequeues a valid word.
  assign fyumi = yumi_en & fvalid;

  bsg_comm_link_reassembler #(
    .channel_width_p(8),
    .core_channels_p(4),
    .link_channels_p(4)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .active_channels_i(mask),
    .unfused_valid_i  (valid),
    .unfused_data_i   (udata),
    .unfused_yumi_o   (uyumi),
    .fused_valid_o    (fvalid),
    .fused_data_o     (fdata),
    .fused_yumi_i     (fyumi)
  );

  typedef struct {
    string       name;
    logic [3:0]  mask;
    int          n;
    logic [7:0]  first;
    logic [7:0]  step;
    logic [15:0] chans;  // channel of slice j in [2*j +: 2]
    logic [63:0] words;  // word w in [32*w +: 32]
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Every dequeued word must be the oldest expected one.
  always @(negedge clk) begin
    if (fvalid && fyumi) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected no word", fdata);
      end else begin
        check("fused_word", fdata, sb.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 4'b0000;
    for (int c = 0; c < 4; c++) udata[c] = 8'h00;
  endtask

  // All channels valid; the intended one carries the real slice, the rest junk.
  task automatic present(input int ch, input logic [7:0] v);
    valid = 4'b1111;
    for (int c = 0; c < 4; c++) udata[c] = (c == ch) ? v : (8'hE0 | 8'(c));
  endtask

  task automatic do_reset(input logic [3:0] m);
    reset   = 1'b1;
    mask    = m;
    yumi_en = 1'b0;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    check("reset_valid", 32'(fvalid), 32'd0);
    check("reset_data", fdata, 32'h0);
    check("reset_yumi", 32'(uyumi), 32'd0);
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] s;
    logic [3:0] ey;
    int         ch;
    do_reset(v.mask);
    yumi_en = 1'b1;
    for (int j = 0; j < v.n; j++) begin
      s  = v.first + 8'(j) * v.step;
      ch = int'(v.chans[2*j +: 2]);
      present(ch, s);
      if (j % 4 == 3) sb.push_back(v.words[32*(j/4) +: 32]);
      @(negedge clk);
      ey = 4'b0001 << ch;
      check({v.name, "_yumi"}, 32'(uyumi), 32'(ey));
      check({v.name, "_valid"}, 32'(fvalid), (j > 0 && (j - 1) % 4 == 3) ? 32'd1 : 32'd0);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check({v.name, "_last_valid"}, 32'(fvalid), (v.n % 4 == 0) ? 32'd1 : 32'd0);
    next_cycle();
    check({v.name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    reset   = 1'b1;
    mask    = 4'b1111;
    yumi_en = 1'b0;
    idle_inputs();

    vecs[0] = '{"all4", 4'b1111, 4, 8'h11, 8'h11,
                {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                {32'h0, 32'h44332211}};
    vecs[1] = '{"mask1011", 4'b1011, 8, 8'h01, 8'h01,
                {2'd1, 2'd0, 2'd3, 2'd1, 2'd0, 2'd3, 2'd1, 2'd0},
                {32'h08070605, 32'h04030201}};
    vecs[2] = '{"single_ch2", 4'b0100, 8, 8'hA0, 8'h01,
                {8{2'd2}},
                {32'hA7A6A5A4, 32'hA3A2A1A0}};
    vecs[3] = '{"mask1100", 4'b1100, 8, 8'h50, 8'h10,
                {4{2'd3, 2'd2}},
                {32'hC0B0A090, 32'h80706050}};
    vecs[4] = '{"stream4", 4'b1111, 8, 8'h10, 8'h01,
                {2{2'd3, 2'd2, 2'd1, 2'd0}},
                {32'h17161514, 32'h13121110}};

    next_cycle();
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Output full with no consumer: the final slice of word1 must stall.
    do_reset(4'b1111);
    for (int j = 0; j < 4; j++) begin
      present(j, 8'(j + 1));
      if (j == 3) sb.push_back(32'h04030201);
      @(negedge clk);
      check("stall_w0_yumi", 32'(uyumi), 32'(4'b0001 << j));
      next_cycle();
    end
    for (int j = 0; j < 3; j++) begin
      present(j, 8'(j + 5));
      @(negedge clk);
      check("stall_w1_yumi", 32'(uyumi), 32'(4'b0001 << j));
      check("stall_w0_valid", 32'(fvalid), 32'd1);
      check("stall_w0_data", fdata, 32'h04030201);
      next_cycle();
    end
    present(3, 8'h08);
    sb.push_back(32'h08070605);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stall_final_yumi", 32'(uyumi), 32'd0);
      check("stall_hold_data", fdata, 32'h04030201);
      next_cycle();
    end
    yumi_en = 1'b1;
    @(negedge clk);
    check("release_yumi", 32'(uyumi), 32'(4'b1000));
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("release_w1_valid", 32'(fvalid), 32'd1);
    next_cycle();
    @(negedge clk);
    check("release_idle_valid", 32'(fvalid), 32'd0);
    check("release_drained", 32'(sb.size()), 32'd0);
    next_cycle();

    // Reset mid-word with a pending word: both are discarded.
    do_reset(4'b1111);
    for (int j = 0; j < 6; j++) begin
      present(j % 4, 8'(j + 1));
      @(negedge clk);
      check("midrst_yumi", 32'(uyumi), 32'(4'b0001 << (j % 4)));
      next_cycle();
    end
    reset = 1'b1;
    present(2, 8'h07);
    @(negedge clk);
    check("midrst_yumi_gated", 32'(uyumi), 32'd0);
    next_cycle();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("midrst_valid", 32'(fvalid), 32'd0);
    check("midrst_data", fdata, 32'h0);
    next_cycle();
    yumi_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      present(j, 8'h21 + 8'(j));
      if (j == 3) sb.push_back(32'h24232221);
      @(negedge clk);
      check("postrst_yumi", 32'(uyumi), 32'(4'b0001 << j));
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    check("postrst_valid", 32'(fvalid), 32'd1);
    next_cycle();
    check("postrst_drained", 32'(sb.size()), 32'd0);

    // Empty mask: nothing is ever taken.
    do_reset(4'b0000);
    yumi_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      present(j, 8'h5A);
      @(negedge clk);
      check("nomask_yumi", 32'(uyumi), 32'd0);
      check("nomask_valid", 32'(fvalid), 32'd0);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
